// File: rtl/reg_bank_mux_pkg.sv
// Shared types and constants for the register bank with registered, handshaked read port.
package reg_bank_mux_pkg;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefNum   = 4;

    // Address width for a bank of num entries; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/out_stage_reg.sv
// One-entry valid/ready pipeline register; state encodes out_valid directly.
module out_stage_reg
    import reg_bank_mux_pkg::*;
#(
    parameter int unsigned PW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    output logic [PW-1:0] out_data,
    input  logic          out_ready
);

    out_state_e    state_q, state_d;
    logic [PW-1:0] data_q, data_d;
    logic          accept;

    always_comb begin
        in_ready = (state_q == StEmpty) || out_ready;
        accept   = in_valid && in_ready;
        state_d  = state_q;
        data_d   = data_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull: begin
                if (accept)         state_d = StFull;
                else if (out_ready) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
        if (accept) data_d = in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;

endmodule

// File: rtl/reg_bank_mux.sv
// NUM-entry register bank with one write port, bank clear, and a registered read port
// that bypasses same-cycle writes and flags out-of-range selects.
module reg_bank_mux
    import reg_bank_mux_pkg::*;
#(
    parameter int unsigned     WIDTH     = DefWidth,
    parameter int unsigned     NUM       = DefNum,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned    SEL_W     = sel_width(NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [SEL_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr,
    input  logic             rd_valid,
    input  logic [SEL_W-1:0] rd_sel,
    output logic             rd_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_err,
    input  logic             out_ready
);

    localparam int unsigned    PW   = WIDTH + SEL_W + 1;
    localparam logic [SEL_W:0] NumL = (SEL_W + 1)'(NUM);

    logic [WIDTH-1:0] bank_q [NUM];
    logic [WIDTH-1:0] bank_d [NUM];
    logic             rd_in_range;
    logic [WIDTH-1:0] rd_data;
    logic [PW-1:0]    out_payload;

    // Write wins over clear for its own entry; out-of-range waddr matches no entry.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            bank_d[i] = bank_q[i];
            if (clr) bank_d[i] = RESET_VAL;
            if (wen && (waddr == SEL_W'(i))) bank_d[i] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM; i++) bank_q[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM; i++) bank_q[i] <= bank_d[i];
        end
    end

    // Read value reflects this cycle's write/clear so an accepted read sees the new contents.
    always_comb begin
        rd_in_range = ({1'b0, rd_sel} < NumL);
        rd_data     = '0;
        if (rd_in_range) begin
            if (wen && (waddr == rd_sel)) begin
                rd_data = wdata;
            end else if (clr) begin
                rd_data = RESET_VAL;
            end else begin
                for (int i = 0; i < NUM; i++) begin
                    if (rd_sel == SEL_W'(i)) rd_data = bank_q[i];
                end
            end
        end
    end

    out_stage_reg #(
        .PW(PW)
    ) u_out_stage (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_valid),
        .in_ready (rd_ready),
        .in_data  ({rd_data, rd_sel, !rd_in_range}),
        .out_valid(out_valid),
        .out_data (out_payload),
        .out_ready(out_ready)
    );

    assign {out_data, out_sel, out_err} = out_payload;

endmodule

// File: tb/tb_reg_bank_mux.sv
// Drives a NUM=4 and a NUM=5 bank with shared stimulus and checks both against an array model.
module tb_reg_bank_mux;

    localparam logic [7:0] RV = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       wen, clr, rd_valid, out_ready;
    logic [2:0] waddr, rd_sel;
    logic [7:0] wdata;

    logic       rdy4, ov4, oe4;
    logic [7:0] od4;
    logic [1:0] os4;
    logic       rdy5, ov5, oe5;
    logic [7:0] od5;
    logic [2:0] os5;

    reg_bank_mux #(.WIDTH(8), .NUM(4), .RESET_VAL(RV)) dut4 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr[1:0]), .wdata(wdata), .clr(clr),
        .rd_valid(rd_valid), .rd_sel(rd_sel[1:0]), .rd_ready(rdy4), .out_valid(ov4),
        .out_data(od4), .out_sel(os4), .out_err(oe4), .out_ready(out_ready)
    );

    reg_bank_mux #(.WIDTH(8), .NUM(5), .RESET_VAL(RV)) dut5 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .clr(clr),
        .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_ready(rdy5), .out_valid(ov5),
        .out_data(od5), .out_sel(os5), .out_err(oe5), .out_ready(out_ready)
    );

    // Model: index 0 is the NUM=4 bank, index 1 the NUM=5 bank.
    logic [7:0] mem [2][8];
    logic       ev [2];
    logic [7:0] ed [2];
    logic [2:0] es [2];
    logic       ee [2];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    function automatic int num_of(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic logic [2:0] addr_of(input int d, input logic [2:0] a);
        return (d == 0) ? {1'b0, a[1:0]} : a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mem[d][i] = RV;
            ev[d] = 1'b0;
            ed[d] = 8'h00;
            es[d] = 3'd0;
            ee[d] = 1'b0;
        end
    endtask

    // Apply current inputs for one clock edge and advance the model.
    task automatic cycle();
        logic       c_wen, c_clr, c_rv, c_ordy, acc;
        logic [2:0] c_wa, c_rs;
        logic [7:0] c_wd;
        c_wen  = wen;
        c_clr  = clr;
        c_rv   = rd_valid;
        c_ordy = out_ready;
        c_wa   = waddr;
        c_rs   = rd_sel;
        c_wd   = wdata;
        acc    = c_rv && (!ev[0] || c_ordy);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                logic [2:0] ra, wa;
                ra = addr_of(d, c_rs);
                wa = addr_of(d, c_wa);
                if (acc) begin
                    ev[d] = 1'b1;
                    es[d] = ra;
                    if (int'(ra) >= num_of(d)) begin
                        ed[d] = 8'h00;
                        ee[d] = 1'b1;
                    end else begin
                        ee[d] = 1'b0;
                        if (c_wen && wa == ra) ed[d] = c_wd;
                        else if (c_clr)        ed[d] = RV;
                        else                   ed[d] = mem[d][ra];
                    end
                end else if (c_ordy) begin
                    ev[d] = 1'b0;
                end
                if (c_clr) for (int i = 0; i < 8; i++) mem[d][i] = RV;
                if (c_wen && int'(wa) < num_of(d)) mem[d][wa] = c_wd;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid4", 32'(ov4), 32'(ev[0]));
            check("rd_ready4", 32'(rdy4), 32'(!ev[0] || out_ready));
            check("out_valid5", 32'(ov5), 32'(ev[1]));
            check("rd_ready5", 32'(rdy5), 32'(!ev[1] || out_ready));
            if (ev[0]) begin
                check("out_data4", 32'(od4), 32'(ed[0]));
                check("out_sel4", 32'(os4), 32'(es[0][1:0]));
                check("out_err4", 32'(oe4), 32'(ee[0]));
            end
            if (ev[1]) begin
                check("out_data5", 32'(od5), 32'(ed[1]));
                check("out_sel5", 32'(os5), 32'(es[1]));
                check("out_err5", 32'(oe5), 32'(ee[1]));
            end
        end
    end

    initial begin
        wen = 1'b0; clr = 1'b0; rd_valid = 1'b0; out_ready = 1'b1;
        waddr = 3'd0; rd_sel = 3'd0; wdata = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;
        check("rst_out_valid", 32'(ov4), 32'd0);
        check("rst_rd_ready", 32'(rdy4), 32'd1);
        check("rst_out_data", 32'(od4), 32'd0);
        check("rst_out_err", 32'(oe5), 32'd0);

        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1; rd_sel = 3'(i);
            cycle();
            check("rst_read_data", 32'(od4), 32'h5A);
            check("rst_read_err", 32'(oe4), 32'd0);
        end
        rd_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wen = 1'b1; waddr = 3'(i); wdata = 8'(8'h11 * (i + 1));
            cycle();
        end
        wen = 1'b0;

        rd_valid = 1'b1; rd_sel = 3'd2;
        cycle();
        rd_valid = 1'b0;
        check("read2_data", 32'(od4), 32'h33);
        check("read2_sel", 32'(os4), 32'd2);
        check("model_pin_read2", 32'(ed[0]), 32'h33);

        wen = 1'b1; waddr = 3'd1; wdata = 8'hA5; rd_valid = 1'b1; rd_sel = 3'd1;
        cycle();
        wen = 1'b0;
        check("bypass_data", 32'(od4), 32'hA5);
        cycle();
        check("after_bypass_data", 32'(od4), 32'hA5);

        rd_sel = 3'd3;
        cycle();
        check("bp_first", 32'(od4), 32'h44);
        out_ready = 1'b0; rd_sel = 3'd0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold_data", 32'(od4), 32'h44);
            check("bp_hold_ready", 32'(rdy4), 32'd0);
            check("bp_hold_valid", 32'(ov4), 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_data", 32'(od4), 32'h11);
        rd_valid = 1'b0;
        cycle();
        check("bp_no_dup", 32'(ov4), 32'd0);

        clr = 1'b1; wen = 1'b1; waddr = 3'd4; wdata = 8'h77;
        cycle();
        clr = 1'b0; wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_valid = 1'b1; rd_sel = 3'(i);
            cycle();
            check("clr_wen_read5", 32'(od5), (i == 4) ? 32'h77 : 32'h5A);
        end
        rd_valid = 1'b0;
        wen = 1'b1; waddr = 3'd6; wdata = 8'hEE;
        cycle();
        wen = 1'b0; rd_valid = 1'b1; rd_sel = 3'd6;
        cycle();
        check("oor_data5", 32'(od5), 32'd0);
        check("oor_err5", 32'(oe5), 32'd1);
        check("alias_data4", 32'(od4), 32'hEE);
        check("alias_err4", 32'(oe4), 32'd0);
        for (int i = 0; i < 5; i++) begin
            rd_sel = 3'(i);
            cycle();
        end
        check("oor_write_ignored", 32'(od5), 32'h77);

        repeat (600) begin
            wen       = 1'($urandom_range(0, 1));
            waddr     = 3'($urandom);
            wdata     = 8'($urandom);
            clr       = ($urandom_range(0, 15) == 0);
            rd_valid  = ($urandom_range(0, 3) != 0);
            rd_sel    = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        wen = 1'b0; clr = 1'b0; out_ready = 1'b0; rd_valid = 1'b1; rd_sel = 3'd2;
        cycle();
        rd_valid = 1'b0;
        check("pre_reset_valid", 32'(ov4), 32'd1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("async_reset_valid4", 32'(ov4), 32'd0);
        check("async_reset_valid5", 32'(ov5), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_valid = 1'b1; rd_sel = 3'(i);
            cycle();
            check("post_reset_read5", 32'(od5), 32'h5A);
            if (i < 4) check("post_reset_read4", 32'(od4), 32'h5A);
        end
        rd_valid = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
